// File: rtl/frame_config_pkg.sv
// Shared types and constants for the frame configuration writer.
// State encoding plus CRC-8 polynomial and seed.
package frame_config_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        STROBE,
        HOLD,
        DONE,
        CHECK
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

endpackage

// File: rtl/frame_config_writer_if.sv
// Configuration word stream: {address, data} words with valid/ready.
// The loader is the master, the writer is the slave.
interface frame_config_writer_if #(
    parameter int ADDR_WIDTH = 8
);

    logic                  s_valid;
    logic                  s_ready;
    logic [ADDR_WIDTH:0]   s_word;

    modport master (
        output s_valid,
        output s_word,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_word,
        output s_ready
    );

endinterface

// File: rtl/frame_config_crc8.sv
// Combinational CRC-8 step over one W-bit word, MSB first.
// Used only when FRAME_CONFIG_WRITER_CRC_EN is defined.
module frame_config_crc8
    import frame_config_pkg::*;
#(
    parameter int W = 9
) (
    input  logic [7:0]   crc_in,
    input  logic [W-1:0] word,
    output logic [7:0]   crc_out
);

    logic [7:0] c;

    always_comb begin
        c = crc_in;
        for (int i = W - 1; i >= 0; i--) begin
            if (c[7] ^ word[i]) begin
                c = {c[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/frame_config_writer.sv
// Drives address/data_in/enable, one configuration bit per stream word.
// Optional trailer CRC check with FRAME_CONFIG_WRITER_CRC_EN.
module frame_config_writer
    import frame_config_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int CNT_WIDTH    = 16,
    parameter int SETUP_CYCLES = 1,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                  prog_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  bit_count,
    frame_config_writer_if.slave  s,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  data_in,
    output logic                  enable,
    output logic                  busy,
`ifdef FRAME_CONFIG_WRITER_CRC_EN
    output logic                  crc_err,
`endif
    output logic                  done
);

`ifdef FRAME_CONFIG_WRITER_CRC_EN
    localparam state_t LAST_ST = CHECK;
`else
    localparam state_t LAST_ST = DONE;
`endif

    state_t               state, state_n;
    logic [3:0]           dly;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 s_ready_q;
    logic                 s_ready_d, enable_d, busy_d, done_d;
    logic                 accept, start_ok;
    logic                 setup_end, hold_end, last_word;

    assign s.s_ready = s_ready_q;
    assign accept    = s.s_valid && s_ready_q;
    assign start_ok  = start && (state == IDLE || state == DONE);
    assign setup_end = (dly == 4'(SETUP_CYCLES - 1));
    assign hold_end  = (dly == 4'(HOLD_CYCLES - 1));
    assign last_word = (cnt == CNT_WIDTH'(1));

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge prog_clk) begin
        if (reset) begin
            state     <= IDLE;
            dly       <= '0;
            cnt       <= '0;
            s_ready_q <= 1'b0;
            enable    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            address   <= '0;
            data_in   <= 1'b0;
        end else begin
            state     <= state_n;
            dly       <= (state_n == state) ? dly + 4'd1 : 4'd0;
            s_ready_q <= s_ready_d;
            enable    <= enable_d;
            busy      <= busy_d;
            done      <= done_d;
            if (start_ok) begin
                cnt <= bit_count;
            end else if (state == HOLD && hold_end) begin
                cnt <= cnt - CNT_WIDTH'(1);
            end
            if (accept && state == LOAD) begin
                address <= s.s_word[ADDR_WIDTH:1];
                data_in <= s.s_word[0];
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = (bit_count == '0) ? DONE : LOAD;
                end
            end
            LOAD:    if (accept) state_n = SETUP;
            SETUP:   if (setup_end) state_n = STROBE;
            STROBE:  state_n = HOLD;
            HOLD: begin
                if (hold_end) begin
                    state_n = last_word ? LAST_ST : LOAD;
                end
            end
            CHECK:   if (accept) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        s_ready_d = (state_n == LOAD) || (state_n == CHECK);
        enable_d  = (state_n == STROBE);
        done_d    = (state_n == DONE);
        busy_d    = !((state_n == IDLE) || (state_n == DONE));
    end

`ifdef FRAME_CONFIG_WRITER_CRC_EN
    logic [7:0] crc, crc_n;

    frame_config_crc8 #(
        .W (ADDR_WIDTH + 1)
    ) u_crc (
        .crc_in  (crc),
        .word    (s.s_word),
        .crc_out (crc_n)
    );

    // Only data words feed the CRC; the trailer is compared against it.
    always_ff @(posedge prog_clk) begin
        if (reset) begin
            crc     <= CRC8_INIT;
            crc_err <= 1'b0;
        end else if (start_ok) begin
            crc     <= CRC8_INIT;
            crc_err <= 1'b0;
        end else if (accept && state == LOAD) begin
            crc     <= crc_n;
        end else if (accept && state == CHECK) begin
            crc_err <= (s.s_word[7:0] != crc);
        end
    end
`endif

endmodule

// File: tb/tb_frame_config_writer.sv
// Self-checking bench: directed table, corner sequences, random sessions.
// Reference model tracks sessions by timing rules, not by RTL states.
module tb_frame_config_writer;

    localparam int AW = 8;
    localparam int CW = 16;
    localparam int S  = 1;
    localparam int H  = 1;
`ifdef FRAME_CONFIG_WRITER_CRC_EN
    localparam bit CRC = 1'b1;
`else
    localparam bit CRC = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] bit_count = '0;
    logic [AW-1:0] address;
    logic          data_in, enable, busy, done;
    logic          start2 = 1'b0;
    logic [CW-1:0] bit_count2 = '0;
    logic [AW-1:0] address2;
    logic          data_in2, enable2, busy2, done2;
`ifdef FRAME_CONFIG_WRITER_CRC_EN
    logic          crc_err, crc_err2;
`endif

    frame_config_writer_if #(.ADDR_WIDTH(AW)) sif ();
    frame_config_writer_if #(.ADDR_WIDTH(AW)) sif2 ();

    frame_config_writer #(
        .ADDR_WIDTH(AW), .CNT_WIDTH(CW),
        .SETUP_CYCLES(S), .HOLD_CYCLES(H)
    ) dut (
        .prog_clk(clk), .reset(rst), .start(start),
        .bit_count(bit_count), .s(sif),
        .address(address), .data_in(data_in),
        .enable(enable), .busy(busy),
`ifdef FRAME_CONFIG_WRITER_CRC_EN
        .crc_err(crc_err),
`endif
        .done(done)
    );

    frame_config_writer #(
        .ADDR_WIDTH(AW), .CNT_WIDTH(CW),
        .SETUP_CYCLES(3), .HOLD_CYCLES(2)
    ) dut2 (
        .prog_clk(clk), .reset(rst), .start(start2),
        .bit_count(bit_count2), .s(sif2),
        .address(address2), .data_in(data_in2),
        .enable(enable2), .busy(busy2),
`ifdef FRAME_CONFIG_WRITER_CRC_EN
        .crc_err(crc_err2),
`endif
        .done(done2)
    );

    typedef struct {
        logic [AW:0]   word;
        logic [AW-1:0] addr;
        logic          data;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    bit            m_sess = 0;
    int            m_left = 0;
    bit            m_trl = 0;
    int            m_rdy_from = 0;
    int            m_done_from = 0;
    int            m_en_cyc = -1;
    logic [AW-1:0] m_addr = '0;
    logic          m_data = 1'b0;
    bit            m_err = 0;
    bit            m_bits[$];
    bit            m_is_done = 0;

    int            en_cycles[$];
    logic [AW:0]   en_words[$];
    logic [AW:0]   wq[$];
    logic [AW:0]   trailer_w = '0;
    bit            good_trl = 1;
    int            rst_at_en = 0;
    bit            rst_fired = 0;
    bit            done_q = 0;
    int            done_rise = -1;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h",
                     nm, cyc, act, exp);
        end
    endtask

    // CRC as remainder of the augmented session bit stream mod x^8+x^2+x+1.
    function automatic logic [7:0] crc_ref();
        logic [8:0] r = '0;
        foreach (m_bits[i]) begin
            r = {r[7:0], m_bits[i]};
            if (r[8]) r = r ^ 9'h107;
        end
        for (int i = 0; i < 8; i++) begin
            r = {r[7:0], 1'b0};
            if (r[8]) r = r ^ 9'h107;
        end
        return r[7:0];
    endfunction

    task automatic cycle(input bit st, input int n, input bit v,
                         input logic [AW:0] w, input bit r);
        bit e_rdy, e_done, e_busy, e_en, r_eff;
        @(negedge clk);
        cyc++;
        e_done = m_sess && m_left == 0 && !m_trl
                 && cyc >= m_done_from;
        e_busy = m_sess && !e_done;
        e_rdy  = m_sess && (m_left > 0 || m_trl)
                 && cyc >= m_rdy_from;
        e_en   = (cyc == m_en_cyc);
        chk("enable", enable, e_en);
        chk("s_ready", sif.s_ready, e_rdy);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("address", address, m_addr);
        chk("data_in", data_in, m_data);
`ifdef FRAME_CONFIG_WRITER_CRC_EN
        chk("crc_err", crc_err, m_err);
`endif
        m_is_done = e_done;
        if (done === 1'b1 && !done_q) done_rise = cyc;
        done_q = (done === 1'b1);
        r_eff = r;
        if (enable === 1'b1) begin
            en_cycles.push_back(cyc);
            en_words.push_back({address, data_in});
            if (rst_at_en > 0) begin
                rst_at_en--;
                if (rst_at_en == 0) begin
                    r_eff = 1'b1;
                    rst_fired = 1;
                end
            end
        end
        rst = r_eff;
        start = st;
        bit_count = CW'(n);
        sif.s_valid = v;
        sif.s_word = w;
        if (r_eff) begin
            m_sess = 0; m_left = 0; m_trl = 0;
            m_en_cyc = -1; m_addr = '0;
            m_data = 1'b0; m_err = 0;
        end else if (st && !e_busy) begin
            m_sess = 1; m_left = n; m_trl = 0;
            m_err = 0; m_bits.delete();
            m_rdy_from = cyc + 1;
            m_done_from = (n == 0) ? cyc + 1 : 1 << 30;
        end else if (v && e_rdy) begin
            if (m_trl) begin
                m_trl = 0;
                m_done_from = cyc + 1;
                m_err = (w[7:0] != crc_ref());
            end else begin
                m_left--;
                m_addr = w[AW:1];
                m_data = w[0];
                for (int i = AW; i >= 0; i--) m_bits.push_back(w[i]);
                m_en_cyc = cyc + 1 + S;
                m_rdy_from = cyc + 2 + S + H;
                if (m_left == 0) begin
                    if (CRC) m_trl = 1;
                    else m_done_from = cyc + 2 + S + H;
                end
                if (wq.size() > 0) void'(wq.pop_front());
            end
        end
    endtask

    task automatic finish_session(input int vprob, input int budget);
        logic [AW:0] w;
        for (int k = 0; k < budget && !m_is_done; k++) begin
            if (m_trl)
                w = good_trl ? (AW+1)'(crc_ref()) : trailer_w;
            else if (wq.size() > 0)
                w = wq[0];
            else
                w = (AW+1)'($urandom);
            cycle(0, 0, $urandom_range(99) < vprob, w, 0);
        end
        chk("session_done", done, 1);
    endtask

    task automatic run_session(input int n, input int vprob,
                               input int budget);
        cycle(1, n, 0, '0, 0);
        m_is_done = 0;
        finish_session(vprob, budget);
    endtask

    initial begin
        vec_t tbl[3];
        int base, ta, te, tr, n;
        tbl[0] = '{9'h1A5, 8'hD2, 1'b1};
        tbl[1] = '{9'h0FE, 8'h7F, 1'b0};
        tbl[2] = '{9'h001, 8'h00, 1'b1};
        sif.s_valid = 1'b0; sif.s_word = '0;
        sif2.s_valid = 1'b0; sif2.s_word = '0;

        cycle(0, 0, 0, '0, 1);
        chk("rst_address", address, 0);
        chk("rst_enable", enable, 0);
        chk("rst_s_ready", sif.s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        cycle(0, 0, 0, '0, 0);

        en_cycles.delete(); en_words.delete();
        foreach (tbl[i]) wq.push_back(tbl[i].word);
        run_session(3, 100, 60);
        chk("tbl_en_count", en_words.size(), 3);
        for (int i = 0; i < 3 && i < en_words.size(); i++) begin
            chk("tbl_addr", en_words[i][AW:1], tbl[i].addr);
            chk("tbl_data", en_words[i][0], tbl[i].data);
            if (i > 0)
                chk("tbl_spacing", en_cycles[i] - en_cycles[i-1], 4);
        end
`ifndef FRAME_CONFIG_WRITER_CRC_EN
        if (en_cycles.size() > 0)
            chk("done_latency", done_rise - en_cycles[$], 2);
`endif

        base = en_cycles.size();
        run_session(0, 100, 5);
        chk("zero_done", done, 1);
        chk("zero_ready", sif.s_ready, 0);
        cycle(0, 0, 0, '0, 0);
        chk("zero_no_enable", en_cycles.size(), base);

        wq.delete();
        wq.push_back(9'h0AB); wq.push_back(9'h132);
        cycle(1, 2, 0, '0, 0);
        m_is_done = 0;
        base = en_cycles.size();
        for (int k = 0; k < 5; k++) cycle(0, 0, 0, wq[0], 0);
        chk("stall_no_enable", en_cycles.size(), base);
        chk("stall_addr", address, tbl[2].addr);
        chk("stall_data", data_in, tbl[2].data);
        finish_session(100, 40);
        chk("stall_resume", en_cycles.size(), base + 2);

        wq.delete();
        wq.push_back(9'h111); wq.push_back(9'h0C3);
        wq.push_back(9'h07E);
        rst_at_en = 2; rst_fired = 0;
        cycle(1, 3, 0, '0, 0);
        for (int k = 0; k < 30 && !rst_fired; k++)
            cycle(0, 0, 1, wq.size() > 0 ? wq[0] : '0, 0);
        chk("rst_fired", rst_fired, 1);
        cycle(0, 0, 0, '0, 0);
        chk("midrst_enable", enable, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", sif.s_ready, 0);
        chk("midrst_addr", address, 0);
        chk("midrst_data", data_in, 0);
        wq.delete(); wq.push_back(9'h0F1);
        run_session(1, 100, 30);
        if (en_words.size() > 0)
            chk("clean_word", en_words[$], 9'h0F1);

        start2 = 1'b1; bit_count2 = 2;
        sif2.s_valid = 1'b1; sif2.s_word = 9'h155;
        ta = -1; te = -1; tr = -1;
        for (int k = 0; k < 30; k++) begin
            cycle(0, 0, 0, '0, 0);
            start2 = 1'b0;
            if (ta < 0 && sif2.s_ready) ta = cyc;
            else if (ta >= 0 && te < 0 && enable2) begin
                te = cyc;
                chk("s3h2_addr", address2, 8'hAA);
                chk("s3h2_data", data_in2, 1);
            end else if (te >= 0 && tr < 0 && sif2.s_ready)
                tr = cyc;
        end
        chk("s3h2_enable", te - ta, 4);
        chk("s3h2_ready", tr - ta, 7);
        chk("s3h2_done", done2, 1);
        chk("s3h2_busy", busy2, 0);
        sif2.s_valid = 1'b0;

`ifdef FRAME_CONFIG_WRITER_CRC_EN
        good_trl = 0;
        trailer_w = 9'h007;
        wq.delete(); wq.push_back(9'h001);
        run_session(1, 100, 30);
        chk("crc_good_err", crc_err, 0);
        trailer_w = 9'h008;
        wq.delete(); wq.push_back(9'h001);
        run_session(1, 100, 30);
        chk("crc_bad_err", crc_err, 1);
        chk("crc_bad_done", done, 1);
        good_trl = 1;
`endif

        for (int sN = 0; sN < 8; sN++) begin
            n = $urandom_range(6, 1);
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back((AW+1)'($urandom));
            good_trl = $urandom_range(1, 0) == 1;
            trailer_w = (AW+1)'($urandom);
            run_session(n, $urandom_range(90, 30), n * 20 + 40);
            for (int k = 0; k < 3; k++)
                cycle($urandom_range(3, 0) == 0, 0, 0, '0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/frame_config_writer.md
# frame_config_writer

Programming-side driver for the frame-based configuration protocol used by logical tiles: it consumes a stream of {address, data} configuration words and drives the shared `address` / `data_in` / `enable` bus so that exactly one configuration bit is written per word. It sits between the bitstream loader and the tile-level address decoders, on the programming clock domain, and reports completion (and optionally integrity) to the loader.

## Interface
- `ADDR_WIDTH`, 8: width of the `address` bus; must be at least 7.
- `CNT_WIDTH`, 16: width of the word counter and `bit_count`.
- `SETUP_CYCLES`, 1: cycles for which address/data are stable before `enable` rises; range 1–15.
- `HOLD_CYCLES`, 1: cycles for which address/data are stable after `enable` falls; range 1–15.

Ports:
- `prog_clk` input 1: programming clock; the block's only clock.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle pulse that begins a session; sampled only in IDLE or DONE.
- `bit_count` input CNT_WIDTH: number of words in the session, sampled with `start`.
- `s_valid` input 1: stream word valid.
- `s_ready` output 1: stream word accepted when `s_valid && s_ready`.
- `s_word` input ADDR_WIDTH+1: `{address, data}`; the LSB is the data bit.
- `address` output ADDR_WIDTH: configuration address.
- `data_in` output 1: configuration data bit.
- `enable` output 1: write strobe, one cycle per word.
- `busy` output 1: a session is in progress.
- `done` output 1: the session is complete; held until the next `start` or `reset`.
- `crc_err` output 1: CRC mismatch; present only with the CRC macro.

## Operation
- States: IDLE, LOAD, SETUP, STROBE, HOLD, DONE. With the CRC macro there is also CHECK.
- IDLE/DONE:
  - `start` with `bit_count == 0` goes to DONE.
  - `start` with a non-zero count loads the counter and goes to LOAD.
- LOAD: `s_ready=1`. On accept, register `address`/`data_in` from `s_word` and go to SETUP.
- SETUP: `enable=0` for SETUP_CYCLES, then go to STROBE.
- STROBE: `enable=1` for exactly 1 cycle, then go to HOLD.
- HOLD: `enable=0` for HOLD_CYCLES, then decrement the counter:
  - zero goes to DONE (or CHECK with the CRC macro);
  - otherwise go to LOAD.
- `address`/`data_in` keep their last value outside SETUP/STROBE/HOLD; they change only on accept.
- `busy` = state is not IDLE and not DONE.
- `done` is 1 only in DONE.
- `start` while `busy` is ignored.
- `s_valid` outside LOAD is ignored; the word is not consumed.

## Timing
- Reset values: `address=0`, `data_in=0`, `enable=0`, `s_ready=0`, `busy=0`, `done=0`, `crc_err=0`; state is IDLE.
- All outputs are registered.
- `start` at edge t: `busy=1` and `s_ready=1` from t+1.
- Word accepted at edge t:
  - `address`/`data_in` valid from t+1;
  - `enable` high during cycle t+1+SETUP_CYCLES;
  - `s_ready` returns at t+2+SETUP_CYCLES+HOLD_CYCLES.
- Defaults give 4 cycles per word.
- Last HOLD cycle ends, then `done=1` and `busy=0` on the next cycle.
- `reset` mid-session: all outputs take reset values at that edge; `enable` never stays high across a reset edge; no partial session resumes.
- `start` and `reset` in the same cycle: reset wins.

## Configuration
- `FRAME_CONFIG_WRITER_CRC_EN` defined:
  - A CRC-8 (poly 0x07, init 0x00, MSB-first over all ADDR_WIDTH+1 bits of each accepted data word) runs across the session.
  - After the last HOLD the block enters CHECK with `s_ready=1` and accepts one trailer word; its low 8 bits are compared with the CRC.
  - `crc_err` is set on mismatch, then the block goes to DONE.
  - `crc_err` clears on `start`.
  - `bit_count == 0` sessions skip CHECK.
- Not defined: no CHECK state, no trailer word, and `crc_err` is absent from the port list.

## Structure
- Package `frame_config_pkg`: state enum, `CRC8_POLY = 8'h07`, `CRC8_INIT = 8'h00`.
- Sub-module `frame_config_crc8`: combinational next-CRC over one (ADDR_WIDTH+1)-bit word.
  - Instantiated only under the macro.
  - CRC register lives in the parent.

## Test plan
- Defaults, `bit_count=3`, words 0x1A5/0x0FE/0x001 with `s_valid` always high:
  - three `enable` pulses, 4 cycles apart;
  - address/data_in = (0xD2,1), (0x7F,0), (0x00,1);
  - `done` one cycle after the final HOLD.
- `bit_count=0` start → `done=1` next cycle, no `s_ready`, no `enable`.
- `s_valid` low for 5 cycles in LOAD → no `enable`, outputs frozen; resumes on valid.
- `reset` asserted in the STROBE cycle of word 2 → `enable=0` and all outputs 0 next cycle; new `start` begins a clean session.
- `SETUP_CYCLES=3`, `HOLD_CYCLES=2` → `enable` at t+4 after accept; `s_ready` at t+7.
- CRC macro, single word 0x001 (CRC 0x07): trailer 0x07 gives `crc_err=0`; trailer 0x08 gives `crc_err=1` with `done=1`.
